iddmm_loader: RTL and testbench
===============================

Name: iddmm_loader

Overview:
- Front-end and back-end stage for the IDDMM Montgomery multiplier core.
- Accepts a stream of K-bit operand words (x, then y, then optionally m) and writes them into the core's x/y/m word RAMs through the core's write port.
- Issues the core's task request, then collects the N result words into an internal N-deep buffer.
- Streams the results out with a valid/ready handshake. The next operand frame may load while the previous results drain.

Parameters:
- K, 256, bits per word.
- N, 16, words per operand. Power of two, ≥2.
- ADDR_W, $clog2(N), word address width.

Ports:
- clk  in  1  clock.
- rst  in  1  reset.
- cfg_m1  in  K  Montgomery constant. Latched when the first m word is accepted.
- cfg_reuse_m  in  1  sampled on the first beat of a frame: 1 = frame carries x,y only (2N words).
- s_valid  in  1  operand word valid.
- s_ready  out  1  operand word accepted when s_valid&s_ready.
- s_data  in  K  operand word, least-significant word first.
- wr_ena  out  3  core RAM write enables, one-hot: bit0 x, bit1 y, bit2 m.
- wr_addr  out  ADDR_W  core RAM word address.
- wr_x, wr_y, wr_m  out  K each  core write data; all three carry the same word.
- wr_m1  out  K  latched cfg_m1.
- task_req  out  1  start request to the core.
- task_grant  in  1  core acceptance of task_req.
- task_end  in  1  result word strobe from the core.
- task_res  in  K  result word, valid when task_end=1.
- m_valid  out  1  result word valid.
- m_ready  in  1  downstream accept.
- m_data  out  K  result word, least-significant word first.
- m_last  out  1  marks result word N-1.
- busy  out  1  high whenever state≠LOAD or phase≠X or cnt≠0.
- err  out  1  sticky protocol error flag.

Behaviour:
- Interface (already decided): one clock, clk; reset rst is synchronous and active-high. All outputs are registered.
- Reset values: s_ready=0, wr_ena=0, wr_addr=0, wr_x/wr_y/wr_m=0, wr_m1=0, task_req=0, m_valid=0, m_last=0, busy=0, err=0. Also m_loaded=0, buffer empty, state LOAD, phase X, cnt=0. First cycle after reset: s_ready=1.
- Reset mid-operation: everything aborts and returns to the reset values. The buffer is discarded. The core must be reset in the same cycle.

State LOAD (s_ready=1):
- Each handshake: next cycle wr_ena=onehot(phase) for exactly 1 cycle, wr_addr=cnt, write data=s_data. Then cnt increments.
- At cnt=N-1 the phase advances X→Y→M and cnt wraps to 0.
- After Y: if reuse_m (latched on the x[0] beat) and m_loaded=1, go to ISSUE. Otherwise go to M.
- cfg_reuse_m=1 with m_loaded=0 forces M-phase loading and sets err.
- After M[N-1]: m_loaded←1, go to ISSUE.
- s_ready drops in the cycle after the final beat.

State ISSUE (s_ready=0):
- Waits until the result buffer is empty.
- Then asserts task_req. The earliest assertion is 2 cycles after the final beat, so the last RAM write has landed.
- task_req holds until sampled with task_grant=1. It deasserts the next cycle, and the state moves to RUN.

State RUN:
- Each task_end cycle writes task_res into the buffer at index rc, then rc++.
- After N words: state LOAD, phase X, cnt=0, s_ready=1 next cycle.
- task_end outside RUN is ignored and sets err.

Output buffer:
- N×K storage with rd pointer and count.
- m_valid=(count>0). Words are popped on m_valid&m_ready.
- m_last=1 when rd pointer=N-1.
- The core is never stalled. The buffer cannot overflow because ISSUE waits for empty.
- Push and pop in the same cycle leave count unchanged.

Other:
- No combinational path from s_valid to s_ready, or from m_ready to m_valid.
- Throughput: 1 operand word per cycle while in LOAD.

Test Plan (N=4, K=16):
- Basic frame: reset, then 12 beats with s_valid held, x=1,2,3,4, y=5..8, m=9..12, cfg_m1=0xABCD.
  - wr_ena sequence 001×4, 010×4, 100×4 with wr_addr 0,1,2,3 each phase, 1 cycle after each beat.
  - wr_m1=0xABCD.
  - task_req rises 2 cycles after the last beat and falls after task_grant.
- Result drain: task_end 4 cycles with task_res=0x10,0x11,0x12,0x13, m_ready=1.
  - m_data 0x10..0x13 in order, m_last only on 0x13, then s_ready=1.
- Reuse m: second frame with cfg_reuse_m=1 and 8 beats.
  - No wr_ena[2] pulses; task_req issued after beat 8.
  - Same test from reset with cfg_reuse_m=1: 12 beats expected, err=1.
- Overlap and backpressure: hold m_ready=0 while the next frame loads.
  - Loading completes; task_req stays 0 until all 4 words drain.
  - Toggle m_ready 1/0: no result word is lost or duplicated.
- Gaps and errors: s_valid with random gaps produces contiguous wr_addr. A spurious task_end in LOAD sets err, which stays 1.
- Reset mid-RUN after 2 task_end words: all outputs return to reset values, m_valid=0, and a fresh frame is then processed correctly.

Source files
------------

// File: rtl/iddmm_loader.sv
// iddmm_loader: operand loader, task issuer and result buffer
// wrapped around the IDDMM Montgomery multiplier core.
module iddmm_loader #(
    parameter int K      = 256,
    parameter int N      = 16,
    parameter int ADDR_W = $clog2(N)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [K-1:0]      cfg_m1,
    input  logic              cfg_reuse_m,
    input  logic              s_valid,
    output logic              s_ready,
    input  logic [K-1:0]      s_data,
    output logic [2:0]        wr_ena,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [K-1:0]      wr_x,
    output logic [K-1:0]      wr_y,
    output logic [K-1:0]      wr_m,
    output logic [K-1:0]      wr_m1,
    output logic              task_req,
    input  logic              task_grant,
    input  logic              task_end,
    input  logic [K-1:0]      task_res,
    output logic              m_valid,
    input  logic              m_ready,
    output logic [K-1:0]      m_data,
    output logic              m_last,
    output logic              busy,
    output logic              err
);

    typedef enum logic [1:0] { ST_LOAD, ST_ISSUE, ST_RUN } state_t;
    typedef enum logic [1:0] { PH_X, PH_Y, PH_M } phase_t;

    localparam logic [ADDR_W-1:0] LAST = ADDR_W'(N - 1);

    state_t            r_state;
    state_t            w_state_nxt;
    phase_t            r_phase;
    phase_t            w_phase_nxt;
    logic [ADDR_W-1:0] r_cnt;
    logic [ADDR_W-1:0] w_cnt_nxt;
    logic [ADDR_W-1:0] r_rc;
    logic [ADDR_W-1:0] w_rc_nxt;
    logic [ADDR_W-1:0] r_rd;
    logic [ADDR_W-1:0] w_rd_nxt;
    logic [ADDR_W:0]   r_count;
    logic [ADDR_W:0]   w_count_nxt;
    logic              r_reuse_m;
    logic              r_m_loaded;
    logic [K-1:0]      r_buf [N];

    logic              r_s_ready;
    logic              w_s_ready_nxt;
    logic [2:0]        r_wr_ena;
    logic [2:0]        w_wr_ena_nxt;
    logic [ADDR_W-1:0] r_wr_addr;
    logic [K-1:0]      r_wr_data;
    logic [K-1:0]      r_wr_m1;
    logic              r_task_req;
    logic              w_task_req_nxt;
    logic              r_m_valid;
    logic              w_m_valid_nxt;
    logic [K-1:0]      r_m_data;
    logic [K-1:0]      w_m_data_nxt;
    logic              r_m_last;
    logic              w_m_last_nxt;
    logic              r_busy;
    logic              w_busy_nxt;
    logic              r_err;
    logic              w_err_nxt;

    logic              w_s_hs;
    logic              w_first;
    logic              w_cnt_last;
    logic              w_push;
    logic              w_pop;
    logic              w_grant;
    logic [2:0]        w_onehot;

    assign w_s_hs     = s_valid && r_s_ready && (r_state == ST_LOAD);
    assign w_first    = w_s_hs && (r_phase == PH_X) && (r_cnt == '0);
    assign w_cnt_last = (r_cnt == LAST);
    assign w_push     = task_end && (r_state == ST_RUN);
    assign w_pop      = r_m_valid && m_ready;
    assign w_grant    = (r_state == ST_ISSUE) && r_task_req && task_grant;

    always_comb begin
        case (r_phase)
            PH_Y:    w_onehot = 3'b010;
            PH_M:    w_onehot = 3'b100;
            default: w_onehot = 3'b001;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_LOAD;
            r_phase <= PH_X;
            r_cnt   <= '0;
            r_rc    <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_phase <= w_phase_nxt;
            r_cnt   <= w_cnt_nxt;
            r_rc    <= w_rc_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_phase_nxt = r_phase;
        w_cnt_nxt   = r_cnt;
        w_rc_nxt    = r_rc;
        case (r_state)
            ST_LOAD: begin
                if (w_s_hs) begin
                    w_cnt_nxt = r_cnt + 1'b1;
                    if (w_cnt_last) begin
                        w_cnt_nxt = '0;
                        case (r_phase)
                            PH_X: w_phase_nxt = PH_Y;
                            PH_Y: begin
                                if (r_reuse_m && r_m_loaded) begin
                                    w_phase_nxt = PH_X;
                                    w_state_nxt = ST_ISSUE;
                                end else begin
                                    w_phase_nxt = PH_M;
                                end
                            end
                            default: begin
                                w_phase_nxt = PH_X;
                                w_state_nxt = ST_ISSUE;
                            end
                        endcase
                    end
                end
            end
            ST_ISSUE: begin
                if (w_grant) w_state_nxt = ST_RUN;
            end
            ST_RUN: begin
                if (task_end) begin
                    w_rc_nxt = r_rc + 1'b1;
                    if (r_rc == LAST) w_state_nxt = ST_LOAD;
                end
            end
            default: w_state_nxt = ST_LOAD;
        endcase
    end

    // Request waits one idle cycle after the last RAM write pulse.
    always_comb begin
        w_count_nxt = r_count;
        if (w_push && !w_pop) w_count_nxt = r_count + 1'b1;
        else if (!w_push && w_pop) w_count_nxt = r_count - 1'b1;
        w_rd_nxt       = w_pop ? r_rd + 1'b1 : r_rd;
        w_s_ready_nxt  = (w_state_nxt == ST_LOAD);
        w_wr_ena_nxt   = w_s_hs ? w_onehot : 3'b000;
        w_task_req_nxt = (r_state == ST_ISSUE) && !w_grant &&
                         (r_count == '0) && (r_wr_ena == 3'b000);
        w_m_valid_nxt  = (w_count_nxt != '0);
        w_m_data_nxt   = (w_push && (r_rc == w_rd_nxt)) ?
                         task_res : r_buf[w_rd_nxt];
        w_m_last_nxt   = w_m_valid_nxt && (w_rd_nxt == LAST);
        w_busy_nxt     = (w_state_nxt != ST_LOAD) ||
                         (w_phase_nxt != PH_X) || (w_cnt_nxt != '0);
        w_err_nxt      = r_err ||
                         (w_first && cfg_reuse_m && !r_m_loaded) ||
                         (task_end && (r_state != ST_RUN));
    end

    always_ff @(posedge clk) begin
        if (w_push) r_buf[r_rc] <= task_res;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_rd       <= '0;
            r_count    <= '0;
            r_reuse_m  <= 1'b0;
            r_m_loaded <= 1'b0;
            r_s_ready  <= 1'b0;
            r_wr_ena   <= 3'b000;
            r_wr_addr  <= '0;
            r_wr_data  <= '0;
            r_wr_m1    <= '0;
            r_task_req <= 1'b0;
            r_m_valid  <= 1'b0;
            r_m_data   <= '0;
            r_m_last   <= 1'b0;
            r_busy     <= 1'b0;
            r_err      <= 1'b0;
        end else begin
            r_rd       <= w_rd_nxt;
            r_count    <= w_count_nxt;
            r_s_ready  <= w_s_ready_nxt;
            r_wr_ena   <= w_wr_ena_nxt;
            r_task_req <= w_task_req_nxt;
            r_m_valid  <= w_m_valid_nxt;
            r_m_data   <= w_m_data_nxt;
            r_m_last   <= w_m_last_nxt;
            r_busy     <= w_busy_nxt;
            r_err      <= w_err_nxt;
            if (w_s_hs) begin
                r_wr_addr <= r_cnt;
                r_wr_data <= s_data;
            end
            if (w_first) r_reuse_m <= cfg_reuse_m;
            if (w_s_hs && (r_phase == PH_M) && (r_cnt == '0))
                r_wr_m1 <= cfg_m1;
            if (w_s_hs && (r_phase == PH_M) && w_cnt_last)
                r_m_loaded <= 1'b1;
        end
    end

    assign s_ready  = r_s_ready;
    assign wr_ena   = r_wr_ena;
    assign wr_addr  = r_wr_addr;
    assign wr_x     = r_wr_data;
    assign wr_y     = r_wr_data;
    assign wr_m     = r_wr_data;
    assign wr_m1    = r_wr_m1;
    assign task_req = r_task_req;
    assign m_valid  = r_m_valid;
    assign m_data   = r_m_data;
    assign m_last   = r_m_last;
    assign busy     = r_busy;
    assign err      = r_err;

endmodule

// File: tb/tb_iddmm_loader.sv
// Bench for iddmm_loader (N=4, K=16): directed frames with random
// data, checked against a frame-level model of writes and results.
module tb_iddmm_loader;

    localparam int K  = 16;
    localparam int N  = 4;
    localparam int AW = 2;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [K-1:0]  cfg_m1 = '0;
    logic          cfg_reuse_m = 1'b0;
    logic          s_valid = 1'b0;
    logic          s_ready;
    logic [K-1:0]  s_data = '0;
    logic [2:0]    wr_ena;
    logic [AW-1:0] wr_addr;
    logic [K-1:0]  wr_x;
    logic [K-1:0]  wr_y;
    logic [K-1:0]  wr_m;
    logic [K-1:0]  wr_m1;
    logic          task_req;
    logic          task_grant = 1'b0;
    logic          task_end = 1'b0;
    logic [K-1:0]  task_res = '0;
    logic          m_valid;
    logic          m_ready = 1'b0;
    logic [K-1:0]  m_data;
    logic          m_last;
    logic          busy;
    logic          err;

    iddmm_loader #(.K(K), .N(N), .ADDR_W(AW)) dut (
        .clk(clk), .rst(rst), .cfg_m1(cfg_m1), .cfg_reuse_m(cfg_reuse_m),
        .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
        .wr_ena(wr_ena), .wr_addr(wr_addr),
        .wr_x(wr_x), .wr_y(wr_y), .wr_m(wr_m), .wr_m1(wr_m1),
        .task_req(task_req), .task_grant(task_grant),
        .task_end(task_end), .task_res(task_res),
        .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data),
        .m_last(m_last), .busy(busy), .err(err)
    );

    always #5 clk = ~clk;

    int vectors = 0;
    int miscompares = 0;

    // Model state: what the loader should have remembered so far.
    bit            m_loaded_m = 1'b0;
    logic          err_m = 1'b0;
    logic [K-1:0]  m1_m = '0;
    logic [K-1:0]  fw [3*N];
    int            fw_n = 0;
    logic [K-1:0]  exp_out [$];

    logic [2:0]    obs_ena [$];
    logic [AW-1:0] obs_addr [$];
    logic [K-1:0]  obs_dat [$];
    logic          obs_split [$];
    logic [K-1:0]  out_dat [$];
    logic          out_last [$];

    always @(negedge clk) begin
        if (wr_ena != 3'b000) begin
            obs_ena.push_back(wr_ena);
            obs_addr.push_back(wr_addr);
            obs_dat.push_back(wr_x);
            obs_split.push_back((wr_x !== wr_y) || (wr_x !== wr_m));
        end
        if (m_valid && m_ready) begin
            out_dat.push_back(m_data);
            out_last.push_back(m_last);
        end
    end

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_reset_vals();
        chk("rst_s_ready", 64'(s_ready), 64'(0));
        chk("rst_wr_ena", 64'(wr_ena), 64'(0));
        chk("rst_wr_addr", 64'(wr_addr), 64'(0));
        chk("rst_wr_x", 64'(wr_x), 64'(0));
        chk("rst_wr_y", 64'(wr_y), 64'(0));
        chk("rst_wr_m", 64'(wr_m), 64'(0));
        chk("rst_wr_m1", 64'(wr_m1), 64'(0));
        chk("rst_task_req", 64'(task_req), 64'(0));
        chk("rst_m_valid", 64'(m_valid), 64'(0));
        chk("rst_m_last", 64'(m_last), 64'(0));
        chk("rst_busy", 64'(busy), 64'(0));
        chk("rst_err", 64'(err), 64'(0));
    endtask

    task automatic model_reset();
        m_loaded_m = 1'b0;
        err_m = 1'b0;
        m1_m = '0;
        exp_out.delete();
        out_dat.delete();
        out_last.delete();
    endtask

    task automatic send_frame(input bit reuse, input bit fixed,
                              input int gap_pct);
        int  t;
        bit  acc;
        fw_n = (reuse && m_loaded_m) ? 2 * N : 3 * N;
        if (reuse && !m_loaded_m) err_m = 1'b1;
        for (int i = 0; i < 3 * N; i++)
            fw[i] = fixed ? K'(i + 1) : K'($urandom);
        cfg_m1 = fixed ? 16'hABCD : K'($urandom);
        cfg_reuse_m = reuse;
        obs_ena.delete();
        obs_addr.delete();
        obs_dat.delete();
        obs_split.delete();
        for (int i = 0; i < fw_n; i++) begin
            while ($urandom_range(99) < gap_pct) begin
                s_valid = 1'b0;
                tick();
            end
            s_valid = 1'b1;
            s_data = fw[i];
            acc = 1'b0;
            t = 0;
            while (!acc && t < 100) begin
                @(negedge clk);
                acc = s_ready;
                tick();
                t++;
            end
            chk("beat_accept", 64'(acc), 64'(1));
            if (i == 0) cfg_reuse_m = ~reuse;
        end
        s_valid = 1'b0;
        if (fw_n == 3 * N) begin
            m1_m = cfg_m1;
            m_loaded_m = 1'b1;
        end
    endtask

    task automatic check_issue();
        chk("s_ready_drop", 64'(s_ready), 64'(0));
        chk("req_early0", 64'(task_req), 64'(0));
        tick();
        chk("req_early1", 64'(task_req), 64'(0));
        chk("busy_issue", 64'(busy), 64'(1));
        tick();
        chk("req_rise", 64'(task_req), 64'(1));
    endtask

    task automatic check_writes();
        chk("wr_count", 64'(obs_ena.size()), 64'(fw_n));
        for (int i = 0; i < fw_n && i < obs_ena.size(); i++) begin
            chk("wr_ena", 64'(obs_ena[i]), 64'(3'b001 << (i / N)));
            chk("wr_addr", 64'(obs_addr[i]), 64'(i % N));
            chk("wr_data", 64'(obs_dat[i]), 64'(fw[i]));
            chk("wr_same", 64'(obs_split[i]), 64'(0));
        end
        chk("wr_m1", 64'(wr_m1), 64'(m1_m));
        chk("err", 64'(err), 64'(err_m));
    endtask

    task automatic wait_req();
        int t = 0;
        while (!task_req && t < 100) begin
            tick();
            t++;
        end
        chk("req_wait", 64'(task_req), 64'(1));
    endtask

    task automatic grant_and_run(input int nres, input bit fixed);
        task_grant = 1'b1;
        tick();
        chk("req_fall", 64'(task_req), 64'(0));
        task_grant = 1'b0;
        for (int i = 0; i < nres; i++) begin
            if (!fixed) while ($urandom_range(3) == 0) tick();
            task_end = 1'b1;
            task_res = fixed ? K'(16 + i) : K'($urandom);
            exp_out.push_back(task_res);
            tick();
            task_end = 1'b0;
        end
        if (nres == N) chk("s_ready_back", 64'(s_ready), 64'(1));
    endtask

    task automatic drain(input int pct);
        int t = 0;
        while (out_dat.size() < exp_out.size() && t < 300) begin
            m_ready = ($urandom_range(99) < pct);
            tick();
            t++;
        end
        m_ready = 1'b0;
        chk("out_count", 64'(out_dat.size()), 64'(exp_out.size()));
        for (int i = 0; i < exp_out.size() && i < out_dat.size(); i++) begin
            chk("m_data", 64'(out_dat[i]), 64'(exp_out[i]));
            chk("m_last", 64'(out_last[i]), 64'((i % N) == N - 1));
        end
        tick();
        chk("no_extra", 64'(m_valid), 64'(0));
        exp_out.delete();
        out_dat.delete();
        out_last.delete();
    endtask

    initial begin
        int t;
        // Reset values, then ready one cycle after release.
        rst = 1'b1;
        tick();
        tick();
        chk_reset_vals();
        rst = 1'b0;
        model_reset();
        tick();
        chk("s_ready_init", 64'(s_ready), 64'(1));

        // Basic frame with fixed words and results.
        send_frame(1'b0, 1'b1, 0);
        check_issue();
        check_writes();
        m_ready = 1'b1;
        grant_and_run(N, 1'b1);
        drain(100);
        chk("busy_idle", 64'(busy), 64'(0));

        // Reuse of the loaded modulus: x,y only.
        send_frame(1'b1, 1'b0, 0);
        check_issue();
        check_writes();
        m_ready = 1'b1;
        grant_and_run(N, 1'b0);
        drain(60);

        // Overlap: results held while the next frame loads.
        send_frame(1'b1, 1'b0, 0);
        check_issue();
        check_writes();
        m_ready = 1'b0;
        grant_and_run(N, 1'b0);
        send_frame(1'b0, 1'b0, 20);
        chk("s_ready_drop_ov", 64'(s_ready), 64'(0));
        for (int c = 0; c < 6; c++) begin
            tick();
            chk("req_hold", 64'(task_req), 64'(0));
        end
        check_writes();
        t = 0;
        while (out_dat.size() < N && t < 200) begin
            chk("req_hold_drain", 64'(task_req), 64'(0));
            m_ready = ($urandom_range(1) == 1);
            tick();
            t++;
        end
        drain(50);
        wait_req();
        grant_and_run(N, 1'b0);
        drain(50);

        // Spurious task_end in LOAD, then a gappy frame.
        task_end = 1'b1;
        task_res = K'($urandom);
        tick();
        task_end = 1'b0;
        err_m = 1'b1;
        chk("err_spurious", 64'(err), 64'(1));
        send_frame(1'b0, 1'b0, 40);
        check_issue();
        check_writes();
        grant_and_run(N, 1'b0);
        drain(70);
        chk("err_sticky", 64'(err), 64'(1));

        // Reset in RUN after two results, then a fresh reuse frame.
        send_frame(1'b0, 1'b0, 0);
        check_issue();
        check_writes();
        m_ready = 1'b0;
        grant_and_run(2, 1'b0);
        chk("m_valid_pre_rst", 64'(m_valid), 64'(1));
        rst = 1'b1;
        tick();
        chk_reset_vals();
        rst = 1'b0;
        model_reset();
        tick();
        chk("s_ready_rst2", 64'(s_ready), 64'(1));
        send_frame(1'b1, 1'b0, 0);
        check_issue();
        check_writes();
        m_ready = 1'b1;
        grant_and_run(N, 1'b0);
        drain(100);

        $display("== %0d vectors applied, %0d miscompares ==",
                 vectors, miscompares);
        $finish;
    end

endmodule
